// File: rtl/ripple_count_sampler_pkg.sv
// ripple_count_sampler_pkg: shared FSM state type and default parameters for the ripple count sampler
package ripple_count_sampler_pkg;
   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;
   localparam int CW_D = 4;
   localparam int ACC_W_D = 16;
   localparam int STABLE_N_D = 2;
   localparam int SETTLE_MAX_D = 15;
endpackage

// File: rtl/ripple_count_sampler_if.sv
// ripple_count_sampler_if: valid/ready result channel carrying the captured delta and running total
interface ripple_count_sampler_if
   import ripple_count_sampler_pkg::*;
   #(parameter int CW = CW_D, parameter int ACC_W = ACC_W_D);
   logic out_valid;
   logic out_ready;
   logic [CW-1:0] out_delta;
   logic [ACC_W-1:0] out_total;
   modport master(output out_valid, out_delta, out_total, input out_ready);
   modport slave(input out_valid, out_delta, out_total, output out_ready);
endinterface

// File: rtl/ripple_count_sampler_sync2.sv
// sync2_bus: two-flop bus synchronizer with asynchronous active-low reset
module sync2_bus #(parameter int W = 4) (
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] s1;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         s1 <= '0;
         q <= '0;
      end else begin
         s1 <= d;
         q <= s1;
      end
endmodule

// File: rtl/ripple_count_sampler.sv
// ripple_count_sampler: synchronizes a ripple counter bus, waits for a stable value,
// and accumulates the modulo increment since the last capture into a saturating total
module ripple_count_sampler
   import ripple_count_sampler_pkg::*;
   #(parameter int CW = CW_D,
     parameter int ACC_W = ACC_W_D,
     parameter int STABLE_N = STABLE_N_D,
     parameter int SETTLE_MAX = SETTLE_MAX_D) (
   input  logic             clock,
   input  logic             reset,
   input  logic [CW-1:0]    rc_q,
   input  logic             sample_en,
   input  logic             clr,
   input  logic [ACC_W-1:0] threshold,
   ripple_count_sampler_if.master out,
   output logic             thr_hit,
   output logic             acc_ovf,
   output logic             settle_err
);
   localparam int SW = $clog2(SETTLE_MAX + 1);
   state_t state;
   logic [CW-1:0] sync2, prev, stable, last, delta, delta_c;
   logic [ACC_W-1:0] total, total_nx;
   logic [ACC_W:0] sum;
   logic [2:0] stable_cnt, stable_nx;
   logic [SW-1:0] settle_cnt, settle_nx;
   logic sat;
   sync2_bus #(.W(CW)) u_sync (.clock(clock), .reset(reset), .d(rc_q), .q(sync2));
   always_comb begin
      stable_nx = (sync2 == prev) ? stable_cnt + 3'd1 : 3'd0;
      settle_nx = settle_cnt + 1'b1;
      delta_c = stable - last;
      sum = {1'b0, total} + (ACC_W+1)'(delta_c);
      sat = sum[ACC_W];
      total_nx = sat ? '1 : sum[ACC_W-1:0];
   end
   assign out.out_delta = delta;
   assign out.out_total = total;
   // prev trails sync2 by one cycle regardless of state so the filter is primed on entry to SETTLE
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state <= IDLE;
         prev <= '0;
         stable <= '0;
         last <= '0;
         delta <= '0;
         total <= '0;
         stable_cnt <= '0;
         settle_cnt <= '0;
         thr_hit <= 1'b0;
         acc_ovf <= 1'b0;
         settle_err <= 1'b0;
         out.out_valid <= 1'b0;
      end else begin
         prev <= sync2;
         settle_err <= 1'b0;
         if (clr) begin
            state <= IDLE;
            total <= '0;
            thr_hit <= 1'b0;
            acc_ovf <= 1'b0;
            out.out_valid <= 1'b0;
            if (state == CAPTURE) last <= stable;
         end else
            case (state)
               IDLE:
                  if (sample_en) begin
                     state <= SETTLE;
                     stable_cnt <= '0;
                     settle_cnt <= '0;
                  end
               SETTLE: begin
                  settle_cnt <= settle_nx;
                  stable_cnt <= stable_nx;
                  if (stable_nx == 3'(STABLE_N)) begin
                     state <= CAPTURE;
                     stable <= sync2;
                  end else if (settle_nx == SW'(SETTLE_MAX)) begin
                     settle_err <= 1'b1;
                     state <= IDLE;
                  end
               end
               CAPTURE: begin
                  delta <= delta_c;
                  total <= total_nx;
                  last <= stable;
                  acc_ovf <= acc_ovf | sat;
                  thr_hit <= thr_hit | (total_nx >= threshold);
                  out.out_valid <= 1'b1;
                  state <= HOLD;
               end
               HOLD:
                  if (out.out_ready) begin
                     out.out_valid <= 1'b0;
                     state <= IDLE;
                  end
            endcase
      end
endmodule

// File: doc/ripple_count_sampler.md
Name: ripple_count_sampler

Overview:
- Consumer stage placed directly downstream of the 4-bit JK ripple counter.
- Brings the counter's asynchronous ripple outputs into the system clock domain and filters out ripple transients by waiting for consecutive identical samples.
- On request, computes the modulo-2^CW increment since the previous capture and adds it to a wide saturating total.
- Returns each result over a valid/ready handshake and flags threshold hits and accumulator overflow.

Parameters:
- CW, 4, width of the ripple count input.
- ACC_W, 16, width of the running total and threshold.
- STABLE_N, 2, consecutive equal synchronized samples required before capture (legal range 1..7).
- SETTLE_MAX, 15, maximum cycles spent in SETTLE before abort (must be at least STABLE_N).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rc_q  in  CW  ripple counter q bus; asynchronous to clock.
- sample_en  in  1  capture request; honoured only in IDLE.
- clr  in  1  synchronous clear of total and sticky flags.
- threshold  in  ACC_W  compare value for thr_hit.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_delta  out  CW  increment since previous capture.
- out_total  out  ACC_W  running total after this capture.
- thr_hit  out  1  sticky flag: total >= threshold.
- acc_ovf  out  1  sticky flag: total saturated.
- settle_err  out  1  one-cycle pulse: SETTLE timed out.

Behaviour:
- Reset (reset=0, asynchronous). All state clears: synchronizers, prev, last, stable_cnt, settle_cnt and total go to 0; FSM goes to IDLE. All outputs read 0. last=0 matches the ripple counter's own reset value.
- Synchronizer. Two flops per bit, free-running every cycle. sync2 is the synchronized value; prev holds sync2 from the previous cycle.
- FSM states: IDLE, SETTLE, CAPTURE, HOLD.
- IDLE:
  - sample_en=1 -> SETTLE, with stable_cnt=0 and settle_cnt=0.
  - sample_en is ignored in every other state.
- SETTLE, evaluated each cycle:
  - settle_cnt increments.
  - If sync2==prev, stable_cnt increments; otherwise stable_cnt=0.
  - stable_cnt reaching STABLE_N -> CAPTURE, latching stable=sync2.
  - Otherwise, settle_cnt reaching SETTLE_MAX -> settle_err pulses for 1 cycle and FSM returns to IDLE. last and total are unchanged.
- CAPTURE (one cycle):
  - delta = (stable - last) mod 2^CW, so wrap-around is handled naturally (e.g. last=14, stable=2 -> delta=4).
  - total_next = total + delta, saturating at 2^ACC_W-1. Saturation sets acc_ovf.
  - last updates to stable.
  - thr_hit sets if total_next >= threshold.
  - Go to HOLD.
- HOLD:
  - out_valid=1; out_delta and out_total stay stable until accepted.
  - Transfer occurs on a cycle with out_valid=1 and out_ready=1 -> IDLE on the next cycle.
  - out_ready is a don't-care outside HOLD.
- Latency: with static rc_q, sample_en in cycle t gives out_valid in cycle t+STABLE_N+2.
- Aliasing: more than 2^CW-1 input events between captures aliases. Callers must sample at least once per 2^CW-1 events; the block does not detect this.
- clr (synchronous, highest priority):
  - Clears total, thr_hit and acc_ovf.
  - Returns the FSM to IDLE and drops out_valid.
  - Does not clear last.
  - clr in the CAPTURE cycle: last still updates to stable, delta is discarded, total=0.
- Mid-operation reset: asynchronous return to the reset values above, including an abort of any pending HOLD.

Decomposition:
- Shared package: the FSM state enum (IDLE, SETTLE, CAPTURE, HOLD) and default constants for CW, ACC_W, STABLE_N and SETTLE_MAX.
- One sub-module: sync2_bus, a parameterised two-flop bus synchronizer with active-low asynchronous reset.
- Stability filter, FSM and accumulator stay in the top module.

Test Plan:
- Reset and single capture: hold reset low, release; rc_q=0->3 static; pulse sample_en -> out_valid after STABLE_N+2 cycles with out_delta=3 and out_total=3. Then rc_q=5 and capture -> out_delta=2, out_total=5.
- Wrap: reach last=14 by captures; set rc_q=2 and capture -> out_delta=4, out_total increases by 4.
- Ripple glitch: toggle rc_q between 7 and 8 every cycle for 20 cycles during SETTLE -> settle_err pulses once after SETTLE_MAX cycles, no out_valid, total unchanged. Then a static 8 captures with delta=1 relative to last=7.
- Backpressure: hold out_ready=0 for 10 cycles while rc_q changes -> out_delta and out_total stay constant; out_ready=1 -> single transfer, then IDLE.
- Threshold and saturation: threshold=10; deltas 6 then 5 -> thr_hit rises on the second capture. Preload total near 0xFFFF via repeated captures; next delta -> out_total=0xFFFF, acc_ovf=1. Then clr -> total, thr_hit and acc_ovf all 0.
- clr during CAPTURE: assert clr in the CAPTURE cycle -> no out_valid, total=0. The next capture's delta is measured from the new last, confirming no double counting.
